// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, FSM encoding, reset polarity.
package pipe_ctrl_pkg;

   // Stall bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
   localparam logic [5:0] STALL_NONE    = 6'b000000;
   localparam logic [5:0] STALL_LOADUSE = 6'b000111;
   localparam logic [5:0] STALL_MC      = 6'b001111;

   localparam logic RST_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      CtrlRun    = 2'd0,
      CtrlMcWait = 2'd1,
      CtrlFlush  = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the operands read in ID.
module pipe_ctrl_hazard_detect (
   input  logic       id_reg1_read_i,
   input  logic       id_reg2_read_i,
   input  logic [4:0] id_reg1_addr_i,
   input  logic [4:0] id_reg2_addr_i,
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_wd_i,
   input  logic       ex_wreg_i,
   output logic       loaduse_o
);

   logic ex_load_valid;
   logic reg1_hit;
   logic reg2_hit;

   always_comb begin
      // r0 is hardwired zero, so a load targeting it never produces a usable value
      ex_load_valid = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0);
      reg1_hit      = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
      reg2_hit      = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
      loaduse_o     = ex_load_valid && (reg1_hit || reg2_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, multi-cycle op sequencing with timeout, exception flush.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_reg1_read_i,
   input  logic       id_reg2_read_i,
   input  logic [4:0] id_reg1_addr_i,
   input  logic [4:0] id_reg2_addr_i,
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_wd_i,
   input  logic       ex_wreg_i,
   input  logic       ex_mc_req_i,
   input  logic       mc_done_i,
   input  logic       excp_i,
   output logic [5:0] stall_o,
   output logic       flush_o,
   output logic       mc_start_o,
   output logic       mc_abort_o,
   output logic       mc_timeout_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MC_TIMEOUT - 1);

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             start_q, start_d;
   logic             abort_q, abort_d;
   logic             flush_q, flush_d;
   logic             timeout_q, timeout_d;
   logic             loaduse;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .id_reg1_read_i (id_reg1_read_i),
      .id_reg2_read_i (id_reg2_read_i),
      .id_reg1_addr_i (id_reg1_addr_i),
      .id_reg2_addr_i (id_reg2_addr_i),
      .ex_is_load_i   (ex_is_load_i),
      .ex_wd_i        (ex_wd_i),
      .ex_wreg_i      (ex_wreg_i),
      .loaduse_o      (loaduse)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      start_d   = 1'b0;
      abort_d   = 1'b0;
      flush_d   = 1'b0;
      timeout_d = timeout_q;
      stall_o   = loaduse ? STALL_LOADUSE : STALL_NONE;

      // A request may only start once it has been observed low since the last start
      if (!ex_mc_req_i) begin
         armed_d = 1'b1;
      end

      unique case (state_q)
         CtrlRun: begin
            if (excp_i) begin
               state_d = CtrlFlush;
               flush_d = 1'b1;
               stall_o = STALL_NONE;
            end else if (ex_mc_req_i && armed_q) begin
               state_d = CtrlMcWait;
               start_d = 1'b1;
               cnt_d   = '0;
               armed_d = 1'b0;
               stall_o = STALL_MC;
            end
         end
         CtrlMcWait: begin
            stall_o = STALL_MC;
            cnt_d   = cnt_q + CNT_W'(1);
            if (excp_i) begin
               // A completing op needs no abort even though the exception wins
               state_d = CtrlFlush;
               flush_d = 1'b1;
               abort_d = !mc_done_i;
               stall_o = STALL_NONE;
            end else if (mc_done_i) begin
               state_d = CtrlRun;
               stall_o = STALL_NONE;
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d   = CtrlRun;
               abort_d   = 1'b1;
               timeout_d = 1'b1;
            end
         end
         CtrlFlush: begin
            state_d = CtrlRun;
            stall_o = STALL_NONE;
         end
         default: begin
            state_d = CtrlRun;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         state_q   <= CtrlRun;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
         flush_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         start_q   <= start_d;
         abort_q   <= abort_d;
         flush_q   <= flush_d;
         timeout_q <= timeout_d;
      end
   end

   assign flush_o      = flush_q;
   assign mc_start_o   = start_q;
   assign mc_abort_o   = abort_q;
   assign mc_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with the default timeout, one with MC_TIMEOUT=8.
module tb_pipe_ctrl;

   localparam logic [5:0] SN = 6'b000000;
   localparam logic [5:0] SL = 6'b000111;
   localparam logic [5:0] SM = 6'b001111;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_reg1_read, id_reg2_read;
   logic [4:0] id_reg1_addr, id_reg2_addr;
   logic       ex_is_load, ex_wreg;
   logic [4:0] ex_wd;
   logic       req_a, done_a, req_b, done_b, excp;

   logic [5:0] stall_a, stall_b;
   logic       flush_a, start_a, abort_a, tmo_a;
   logic       flush_b, start_b, abort_b, tmo_b;
   logic [9:0] obs_a, obs_b;

   typedef struct {
      string      tag;
      bit         which;
      logic [9:0] v;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic [9:0] obs;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   assign obs_a = {stall_a, flush_a, start_a, abort_a, tmo_a};
   assign obs_b = {stall_b, flush_b, start_b, abort_b, tmo_b};

   pipe_ctrl dut_a (
      .clk            (clk),
      .rst            (rst),
      .id_reg1_read_i (id_reg1_read),
      .id_reg2_read_i (id_reg2_read),
      .id_reg1_addr_i (id_reg1_addr),
      .id_reg2_addr_i (id_reg2_addr),
      .ex_is_load_i   (ex_is_load),
      .ex_wd_i        (ex_wd),
      .ex_wreg_i      (ex_wreg),
      .ex_mc_req_i    (req_a),
      .mc_done_i      (done_a),
      .excp_i         (excp),
      .stall_o        (stall_a),
      .flush_o        (flush_a),
      .mc_start_o     (start_a),
      .mc_abort_o     (abort_a),
      .mc_timeout_o   (tmo_a)
   );

   pipe_ctrl #(
      .MC_TIMEOUT (8),
      .CNT_W      (4)
   ) dut_b (
      .clk            (clk),
      .rst            (rst),
      .id_reg1_read_i (id_reg1_read),
      .id_reg2_read_i (id_reg2_read),
      .id_reg1_addr_i (id_reg1_addr),
      .id_reg2_addr_i (id_reg2_addr),
      .ex_is_load_i   (ex_is_load),
      .ex_wd_i        (ex_wd),
      .ex_wreg_i      (ex_wreg),
      .ex_mc_req_i    (req_b),
      .mc_done_i      (done_b),
      .excp_i         (excp),
      .stall_o        (stall_b),
      .flush_o        (flush_b),
      .mc_start_o     (start_b),
      .mc_abort_o     (abort_b),
      .mc_timeout_o   (tmo_b)
   );

   function automatic logic [9:0] ov(logic [5:0] st, logic fl, logic sa, logic ab, logic to);
      return {st, fl, sa, ab, to};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input bit which, input logic [9:0] v);
      exp_t e;
      e.tag   = tag;
      e.which = which;
      e.v     = v;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] v);
      checks++;
      assert (o === v) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, o, v);
      end
   endtask

   // Scoreboard drain: one expected entry per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         obs = cur.which ? obs_b : obs_a;
         chk(cur.tag, obs, cur.v);
      end
   end

   initial begin
      rst = 1'b0;
      id_reg1_read = 1'b0; id_reg2_read = 1'b0;
      id_reg1_addr = 5'd0; id_reg2_addr = 5'd0;
      ex_is_load = 1'b0; ex_wreg = 1'b0; ex_wd = 5'd0;
      req_a = 1'b0; done_a = 1'b0; req_b = 1'b0; done_b = 1'b0; excp = 1'b0;

      #12;
      chk("reset_a", obs_a, '0);
      chk("reset_b", obs_b, '0);
      tick(); rst = 1'b1; push("post_reset", 0, ov(SN, 0, 0, 0, 0));
      tick(); push("idle_b", 1, ov(SN, 0, 0, 0, 0));

      // Load-use detection
      tick(); ex_is_load = 1; ex_wreg = 1; ex_wd = 5; id_reg1_addr = 5; id_reg1_read = 1;
      push("lu_hit_r1", 0, ov(SL, 0, 0, 0, 0));
      tick(); ex_wd = 0; id_reg1_addr = 0; push("lu_x0", 0, ov(SN, 0, 0, 0, 0));
      tick(); ex_wd = 5; id_reg1_addr = 5; id_reg1_read = 0;
      push("lu_noread", 0, ov(SN, 0, 0, 0, 0));
      tick(); id_reg2_read = 1; id_reg2_addr = 5; push("lu_hit_r2", 1, ov(SL, 0, 0, 0, 0));
      tick(); ex_wreg = 0; push("lu_nowreg", 0, ov(SN, 0, 0, 0, 0));
      tick(); ex_is_load = 0; ex_wd = 0; id_reg2_read = 0; id_reg2_addr = 0;
      push("lu_clear", 0, ov(SN, 0, 0, 0, 0));

      // 10-cycle divide on the default-timeout instance
      tick(); req_a = 1; push("div_req", 0, ov(SM, 0, 0, 0, 0));
      tick(); push("div_start", 0, ov(SM, 0, 1, 0, 0));
      for (int i = 2; i <= 9; i++) begin
         tick();
         if (i == 2) begin
            ex_is_load = 1; ex_wreg = 1; ex_wd = 7; id_reg1_addr = 7; id_reg1_read = 1;
         end else if (i == 3) begin
            ex_is_load = 0; ex_wreg = 0; ex_wd = 0; id_reg1_addr = 0; id_reg1_read = 0;
         end
         push((i == 2) ? "div_wait_mc_over_lu" : "div_wait", 0, ov(SM, 0, 0, 0, 0));
      end
      tick(); done_a = 1; push("div_done", 0, ov(SN, 0, 0, 0, 0));
      tick(); done_a = 0; push("div_hold_req", 0, ov(SN, 0, 0, 0, 0));
      tick(); push("div_no_restart", 0, ov(SN, 0, 0, 0, 0));
      tick(); req_a = 0; push("div_req_low", 0, ov(SN, 0, 0, 0, 0));

      // Timeout on the MC_TIMEOUT=8 instance
      tick(); req_b = 1; push("to_req", 1, ov(SM, 0, 0, 0, 0));
      tick(); push("to_start", 1, ov(SM, 0, 1, 0, 0));
      for (int i = 2; i <= 8; i++) begin
         tick(); push("to_wait", 1, ov(SM, 0, 0, 0, 0));
      end
      tick(); push("to_abort", 1, ov(SN, 0, 0, 1, 1));
      tick(); push("to_sticky", 1, ov(SN, 0, 0, 0, 1));
      tick(); req_b = 0; push("to_sticky_low", 1, ov(SN, 0, 0, 0, 1));

      // Exception on wait cycle 3
      tick(); req_a = 1; push("ex_req", 0, ov(SM, 0, 0, 0, 0));
      tick(); push("ex_wait1", 0, ov(SM, 0, 1, 0, 0));
      tick(); push("ex_wait2", 0, ov(SM, 0, 0, 0, 0));
      tick(); excp = 1; push("ex_wait3", 0, ov(SN, 0, 0, 0, 0));
      tick(); excp = 0; req_a = 0; push("ex_flush", 0, ov(SN, 1, 0, 1, 0));
      tick(); push("ex_flush_end", 0, ov(SN, 0, 0, 0, 0));

      // Done and exception together
      tick(); req_a = 1; push("both_req", 0, ov(SM, 0, 0, 0, 0));
      tick(); push("both_start", 0, ov(SM, 0, 1, 0, 0));
      tick(); push("both_wait", 0, ov(SM, 0, 0, 0, 0));
      tick(); done_a = 1; excp = 1; push("both_evt", 0, ov(SN, 0, 0, 0, 0));
      tick(); done_a = 0; excp = 0; req_a = 0; push("both_flush", 0, ov(SN, 1, 0, 0, 0));
      tick(); push("both_end", 0, ov(SN, 0, 0, 0, 0));

      // Asynchronous reset during MC_WAIT
      tick(); req_a = 1; push("rs_req", 0, ov(SM, 0, 0, 0, 0));
      tick(); push("rs_start", 0, ov(SM, 0, 1, 0, 0));
      tick(); push("rs_wait", 0, ov(SM, 0, 0, 0, 0));
      @(negedge clk); #1;
      rst = 1'b0; #1;
      chk("rs_async_a", obs_a, '0);
      chk("rs_async_b", obs_b, '0);
      tick(); tick(); rst = 1'b1; push("rs_release", 0, ov(SN, 0, 0, 0, 0));
      tick(); push("rs_req_blocked", 0, ov(SN, 0, 0, 0, 0));
      tick(); req_a = 0; push("rs_req_low", 0, ov(SN, 0, 0, 0, 0));
      tick(); req_a = 1; push("rs_rereq", 0, ov(SM, 0, 0, 0, 0));
      tick(); push("rs_restart", 0, ov(SM, 0, 1, 0, 0));
      tick(); done_a = 1; push("rs_done", 0, ov(SN, 0, 0, 0, 0));
      tick(); done_a = 0; req_a = 0; push("rs_idle", 0, ov(SN, 0, 0, 0, 0));

      @(negedge clk); #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
